fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end of the 16-bit pipeline; closes the loop from the execute stage's nextPC by turning resolved redirects into instruction-memory requests.
- Holds the architectural PC and drives a multi-cycle instruction memory (request/stall/done handshake).
- Presents one registered instruction, its PC and PC+2 to decode under a valid/stall handshake.
- Squashes in-flight fetches on redirect and stops on halt.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset
NOP_INSTR, 16'h0800, value driven on instr when not valid

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous reset, active-low
redirect  in  1  execute resolved a taken branch/jump this cycle
redirect_pc  in  16  target PC (execute nextPC)
halt  in  1  decode saw HALT; stop fetching
stall_in  in  1  decode cannot accept instr this cycle
imem_rd  out  1  read request, combinational from state
imem_addr  out  16  request address (= pc)
imem_stall  in  1  memory busy, request not accepted this cycle
imem_done  in  1  imem_rdata valid this cycle
imem_rdata  in  16  fetched instruction
instr  out  16  registered instruction to decode
pc_out  out  16  PC of instr
pc_plus2  out  16  pc_out + 2 (mod 2^16)
instr_valid  out  1  instr/pc_out/pc_plus2 valid
err  out  1  sticky misaligned-redirect error

Behaviour:
- One clock, clk. Reset is synchronous, active-low on rst_n; every flop is reset from it.
- Reset values while rst_n=0 and the cycle after:
  - pc=RESET_PC; state=FETCH; instr_valid=0; instr=NOP_INSTR; pc_out=0; pc_plus2=0; err=0.
  - imem_rd=0 while rst_n=0.
- Reset mid-operation: any pending memory response is discarded; the memory is reset from the same rst_n.
- States:
  - FETCH: imem_rd=1, imem_addr=pc.
    - Issue only when the output slot is free or consumed this cycle: !instr_valid || !stall_in. Otherwise go to HOLD and keep imem_rd=0.
    - imem_stall=1: stay in FETCH and re-request.
    - Accepted with imem_done=1 in the same cycle: capture and stay in FETCH, giving 1 instr/cycle on a single-cycle memory.
    - Accepted with imem_done=0: go to WAIT.
  - WAIT: imem_rd=0. On imem_done, capture and go to FETCH.
  - HOLD: instr_valid=1 and stall_in=1. Go to FETCH on the first cycle stall_in=0; the consume happens that cycle.
  - DRAIN: a request is outstanding but squashed. Wait for imem_done, discard the data, go to FETCH.
  - HALTED: imem_rd=0, instr_valid=0. Exit only via reset.
- Capture at the edge: instr<=imem_rdata, pc_out<=pc, pc_plus2<=pc+2, instr_valid<=1, pc<=pc+2.
- Consume: instr_valid && !stall_in. instr_valid clears unless a new capture happens the same edge.
- Redirect (highest priority):
  - pc<=redirect_pc; instr_valid<=0; instr<=NOP_INSTR.
  - A response arriving in the same cycle is discarded.
  - From WAIT without imem_done, go to DRAIN; otherwise go to FETCH. Fetch of redirect_pc starts the next cycle.
- Halt: when halt=1 and redirect=0, go to HALTED; instr_valid<=0.
  - Outstanding request: stay in DRAIN, then go to HALTED.
  - redirect and halt in the same cycle: redirect wins and halt is ignored, because the halt belongs to a younger, squashed instruction.
- Misaligned redirect (redirect_pc[0]=1): err<=1 (sticky until reset), go to HALTED (via DRAIN if outstanding), pc<=redirect_pc.
- Arithmetic: PC width 16, increment 2, wrap 16'hFFFE+2=16'h0000 with no error.
- Outputs instr, pc_out, pc_plus2, instr_valid and err are registered. imem_rd and imem_addr are combinational from state and pc.

Decomposition:
- Shared package: state encoding (FETCH, WAIT, HOLD, DRAIN, HALTED), NOP_INSTR, RESET_PC, PC increment constant 2.
- One sub-module: fetch_pc_reg, a 16-bit register with synchronous active-low reset to RESET_PC, a load-redirect path and an increment-enable path.

Test Plan:
- Reset: hold rst_n=0 3 cycles then release -> instr_valid=0, instr=16'h0800, err=0, imem_rd=1 and imem_addr=16'h0000 on the first cycle after release.
- Single-cycle memory (imem_done=1 every request), stall_in=0 -> pc_out 0x0000, 0x0002, 0x0004 on consecutive cycles, pc_plus2 0x0002, 0x0004, 0x0006.
- Multi-cycle memory: done 3 cycles after accept, 1 cycle of imem_stall first -> imem_rd high 2 cycles then low, instr captured exactly once, next fetch at 0x0002.
- Backpressure: stall_in=1 for 4 cycles with instr_valid=1 -> instr/pc_out stable, imem_rd=0. Release -> next instr the following cycle, none lost or duplicated.
- Redirect in WAIT to 0x0100: stale done data never appears; next valid pc_out=0x0100. Redirect with halt the same cycle -> fetch continues at the target.
- Edge cases:
  - halt=1 -> HALTED, imem_rd stays 0 for 10 cycles.
  - Redirect to 0x0101 -> err=1 sticky, instr_valid=0.
  - Fetch at 0xFFFE -> pc_plus2=0x0000, next fetch at 0x0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and PC helper for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [PC_W-1:0]    DEF_RESET_PC  = 16'h0000;
  localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 16'h0800;
  localparam logic [PC_W-1:0]    PC_INC        = 16'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_e;

  // Sequential successor of a PC; wraps modulo 2^16.
  function automatic logic [PC_W-1:0] pc_seq(input logic [PC_W-1:0] pc);
    return PC_W'(pc + PC_INC);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural PC register: redirect load has priority over sequential increment.
module fetch_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        inc,
  output logic [15:0] pc
);

  // PC update: reset, redirect load, or step by one instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_VAL;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc_seq(pc);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives a multi-cycle imem and presents one registered
// instruction to decode, squashing in-flight fetches on redirect and stopping on halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [15:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  input  logic        stall_in,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  output logic        err
);

  fetch_state_e state_q, state_d;
  logic         drain_halt_q, drain_halt_d;
  logic [15:0]  pc;
  logic         slot_free;
  logic         accept;
  logic         capture;
  logic         consume;
  logic         misaligned;
  logic         redirect_eff;

  fetch_pc_reg #(.RESET_VAL(RESET_PC)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (redirect_eff),
    .load_val (redirect_pc),
    .inc      (capture),
    .pc       (pc)
  );

  // Request/capture qualifiers; a redirect or halt cycle never issues, so nothing
  // new is left outstanding behind a squash.
  always_comb begin
    slot_free    = !instr_valid || !stall_in;
    redirect_eff = redirect && (state_q != ST_HALTED);
    misaligned   = redirect && redirect_pc[0];
    imem_rd      = rst_n && (state_q == ST_FETCH) && slot_free && !redirect && !halt;
    imem_addr    = pc;
    accept       = imem_rd && !imem_stall;
    capture      = (accept && imem_done) ||
                   ((state_q == ST_WAIT) && imem_done && !redirect && !halt);
    consume      = instr_valid && !stall_in;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      drain_halt_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_halt_q <= drain_halt_d;
    end
  end

  // Next-state logic; drain_halt remembers whether a drain should end in HALTED.
  always_comb begin
    state_d      = state_q;
    drain_halt_d = drain_halt_q;
    unique case (state_q)
      ST_FETCH: begin
        if (redirect)                   state_d = misaligned ? ST_HALTED : ST_FETCH;
        else if (halt)                  state_d = ST_HALTED;
        else if (!slot_free)            state_d = ST_HOLD;
        else if (accept && !imem_done)  state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect) begin
          if (!imem_done) begin
            state_d      = ST_DRAIN;
            drain_halt_d = misaligned;
          end else begin
            state_d = misaligned ? ST_HALTED : ST_FETCH;
          end
        end else if (halt) begin
          if (!imem_done) begin
            state_d      = ST_DRAIN;
            drain_halt_d = 1'b1;
          end else begin
            state_d = ST_HALTED;
          end
        end else if (imem_done) begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (redirect)       state_d = misaligned ? ST_HALTED : ST_FETCH;
        else if (halt)      state_d = ST_HALTED;
        else if (!stall_in) state_d = ST_FETCH;
      end
      ST_DRAIN: begin
        // A younger halt is cancelled by a redirect; a misaligned target still halts.
        if (redirect)  drain_halt_d = misaligned || err;
        else if (halt) drain_halt_d = 1'b1;
        if (imem_done) state_d = drain_halt_d ? ST_HALTED : ST_FETCH;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    if (state_d != ST_DRAIN) drain_halt_d = 1'b0;
  end

  // Decode-facing output slot and sticky misalignment error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr       <= NOP_INSTR;
      pc_out      <= 16'h0000;
      pc_plus2    <= 16'h0000;
      instr_valid <= 1'b0;
      err         <= 1'b0;
    end else if (redirect_eff) begin
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      if (misaligned) err <= 1'b1;
    end else if (halt || (state_q == ST_HALTED)) begin
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
    end else if (capture) begin
      instr       <= imem_rdata;
      pc_out      <= pc;
      pc_plus2    <= pc_seq(pc);
      instr_valid <= 1'b1;
    end else if (consume) begin
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, multi-cycle sequences,
// and a randomized run against an instruction-stream reference model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        stall_in;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_stall;
  logic        imem_done;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic        err;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .stall_in    (stall_in),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_stall  (imem_stall),
    .imem_done   (imem_done),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc_out      (pc_out),
    .pc_plus2    (pc_plus2),
    .instr_valid (instr_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // ---------------- instruction memory model ----------------
  logic        cfg_zero;
  int          cfg_stall_n;
  int          cfg_lat;
  logic        mem_rand;
  logic        rnd_zero;
  int          rnd_stall_n;
  int          rnd_lat;
  logic        m_zero;
  int          m_stall_n;
  int          m_lat;
  logic        busy;
  logic [15:0] busy_addr;
  int          wait_cnt;
  int          stall_cnt;

  always_comb begin
    m_zero    = mem_rand ? rnd_zero    : cfg_zero;
    m_stall_n = mem_rand ? rnd_stall_n : cfg_stall_n;
    m_lat     = mem_rand ? rnd_lat     : cfg_lat;
  end

  always_comb begin
    imem_stall = 1'b0;
    imem_done  = 1'b0;
    imem_rdata = 16'hDEAD;
    if (m_zero) begin
      imem_done  = imem_rd;
      imem_rdata = mem_word(imem_addr);
    end else begin
      imem_stall = imem_rd && (stall_cnt < m_stall_n);
      if (busy && wait_cnt == 0) begin
        imem_done  = 1'b1;
        imem_rdata = mem_word(busy_addr);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      busy_addr   <= 16'h0000;
      wait_cnt    <= 0;
      stall_cnt   <= 0;
      rnd_zero    <= 1'b0;
      rnd_stall_n <= 1;
      rnd_lat     <= 2;
    end else begin
      if (busy) begin
        if (wait_cnt == 0) begin
          busy <= 1'b0;
          if (mem_rand) begin
            rnd_zero    <= ($urandom_range(0, 2) == 0);
            rnd_stall_n <= int'($urandom_range(0, 2));
            rnd_lat     <= int'($urandom_range(1, 4));
          end
        end else begin
          wait_cnt <= wait_cnt - 1;
        end
      end
      if (!m_zero && imem_rd) begin
        if (stall_cnt < m_stall_n) begin
          stall_cnt <= stall_cnt + 1;
        end else begin
          busy      <= 1'b1;
          busy_addr <= imem_addr;
          wait_cnt  <= m_lat - 1;
          stall_cnt <= 0;
        end
      end
      if (m_zero && imem_rd && mem_rand) begin
        rnd_zero    <= ($urandom_range(0, 2) == 0);
        rnd_stall_n <= int'($urandom_range(0, 2));
        rnd_lat     <= int'($urandom_range(1, 4));
      end
    end
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] rp, input logic h, input logic s);
    @(negedge clk);
    redirect    = r;
    redirect_pc = rp;
    halt        = h;
    stall_in    = s;
    #1;
  endtask

  task automatic do_reset(input logic zero, input int sn, input int lat, input logic rnd);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      halt        = 1'b0;
      stall_in    = 1'b0;
      cfg_zero    = zero;
      cfg_stall_n = sn;
      cfg_lat     = lat;
      mem_rand    = rnd;
      #1;
      chk1("rst_imem_rd", imem_rd, 1'b0);
      if (i > 0) begin
        chk1("rst_valid", instr_valid, 1'b0);
        chk16("rst_instr", instr, DEF_NOP_INSTR);
        chk1("rst_err", err, 1'b0);
        chk16("rst_pc_out", pc_out, 16'h0000);
        chk16("rst_pc_plus2", pc_plus2, 16'h0000);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r;
    logic [15:0] rpc;
    logic        h;
    logic        s;
    logic        exp_rd;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic [15:0] rpc, input logic h,
                              input logic s, input logic rd, input logic [15:0] addr,
                              input logic v, input logic [15:0] p);
    vec_t t;
    t.r = r; t.rpc = rpc; t.h = h; t.s = s;
    t.exp_rd = rd; t.exp_addr = addr; t.exp_valid = v; t.exp_pc = p;
    return t;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic        prev_valid, prev_stall, prev_redirect;
    logic [15:0] prev_pc, prev_instr, exp_pc;
    logic        r, s;
    logic [15:0] rp;
    int          consumed;
    int          vcount;
    logic        seen;

    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0; stall_in = 1'b0;
    cfg_zero = 1'b1; cfg_stall_n = 0; cfg_lat = 1; mem_rand = 1'b0;

    // single-cycle memory stream, backpressure, redirect+halt, wrap, halt
    tbl[0]  = mk(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 16'h0000);
    tbl[1]  = mk(0, 16'h0000, 0, 0, 1, 16'h0002, 1, 16'h0000);
    tbl[2]  = mk(0, 16'h0000, 0, 0, 1, 16'h0004, 1, 16'h0002);
    for (int i = 3; i < 7; i++) tbl[i] = mk(0, 16'h0000, 0, 1, 0, 16'h0006, 1, 16'h0004);
    tbl[7]  = mk(0, 16'h0000, 0, 0, 0, 16'h0006, 1, 16'h0004);
    tbl[8]  = mk(0, 16'h0000, 0, 0, 1, 16'h0006, 0, 16'h0000);
    tbl[9]  = mk(1, 16'h0100, 1, 0, 0, 16'h0008, 1, 16'h0006);
    tbl[10] = mk(0, 16'h0000, 0, 0, 1, 16'h0100, 0, 16'h0000);
    tbl[11] = mk(0, 16'h0000, 0, 0, 1, 16'h0102, 1, 16'h0100);
    tbl[12] = mk(1, 16'hFFFE, 0, 0, 0, 16'h0104, 1, 16'h0102);
    tbl[13] = mk(0, 16'h0000, 0, 0, 1, 16'hFFFE, 0, 16'h0000);
    tbl[14] = mk(0, 16'h0000, 0, 0, 1, 16'h0000, 1, 16'hFFFE);
    tbl[15] = mk(0, 16'h0000, 1, 0, 0, 16'h0002, 1, 16'h0000);
    for (int i = 16; i < NV; i++) tbl[i] = mk(0, 16'h0000, 0, 0, 0, 16'h0002, 0, 16'h0000);

    do_reset(1'b1, 0, 1, 1'b0);
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].r, tbl[i].rpc, tbl[i].h, tbl[i].s);
      chk1("tbl_imem_rd", imem_rd, tbl[i].exp_rd);
      chk16("tbl_imem_addr", imem_addr, tbl[i].exp_addr);
      chk1("tbl_valid", instr_valid, tbl[i].exp_valid);
      chk1("tbl_err", err, 1'b0);
      if (tbl[i].exp_valid) begin
        chk16("tbl_pc_out", pc_out, tbl[i].exp_pc);
        chk16("tbl_pc_plus2", pc_plus2, 16'(tbl[i].exp_pc + 16'd2));
        chk16("tbl_instr", instr, mem_word(tbl[i].exp_pc));
      end else begin
        chk16("tbl_instr_nop", instr, DEF_NOP_INSTR);
      end
    end

    // multi-cycle memory: one stall cycle, done 3 cycles after accept
    do_reset(1'b0, 1, 3, 1'b0);
    step(0, 16'h0000, 0, 0); chk1("mc_rd_c0", imem_rd, 1'b1); chk16("mc_addr_c0", imem_addr, 16'h0000);
    step(0, 16'h0000, 0, 0); chk1("mc_rd_c1", imem_rd, 1'b1);
    step(0, 16'h0000, 0, 0); chk1("mc_rd_c2", imem_rd, 1'b0); chk1("mc_valid_c2", instr_valid, 1'b0);
    step(0, 16'h0000, 0, 0); chk1("mc_rd_c3", imem_rd, 1'b0);
    step(0, 16'h0000, 0, 0); chk1("mc_rd_c4", imem_rd, 1'b0); chk1("mc_valid_c4", instr_valid, 1'b0);
    step(0, 16'h0000, 0, 0);
    chk1("mc_valid_c5", instr_valid, 1'b1);
    chk16("mc_pc_c5", pc_out, 16'h0000);
    chk16("mc_instr_c5", instr, mem_word(16'h0000));
    chk1("mc_rd_c5", imem_rd, 1'b1);
    chk16("mc_addr_c5", imem_addr, 16'h0002);
    vcount = 1;
    for (int i = 0; i < 4; i++) begin
      step(0, 16'h0000, 0, 0);
      if (instr_valid) vcount++;
    end
    total++;
    if (vcount != 1) begin
      bad++;
      $display("FAIL mc_capture_once: got %0d captures expected 1", vcount);
    end
    step(0, 16'h0000, 0, 0);
    chk1("mc_valid_c10", instr_valid, 1'b1);
    chk16("mc_pc_c10", pc_out, 16'h0002);

    // redirect while waiting: stale response must be dropped
    do_reset(1'b0, 0, 3, 1'b0);
    step(0, 16'h0000, 0, 0); chk1("rw_rd_c0", imem_rd, 1'b1);
    step(1, 16'h0100, 0, 0); chk1("rw_rd_c1", imem_rd, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(0, 16'h0000, 0, 0);
      if (instr_valid) begin
        seen = 1'b1;
        chk16("rw_pc_out", pc_out, 16'h0100);
        chk16("rw_instr", instr, mem_word(16'h0100));
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL rw_timeout: got no valid instr expected pc 0100");
    end

    // misaligned redirect: sticky error, fetch stops
    do_reset(1'b1, 0, 1, 1'b0);
    step(0, 16'h0000, 0, 0);
    step(1, 16'h0101, 0, 0); chk1("mis_rd_c1", imem_rd, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(0, 16'h0000, 0, 0);
      chk1("mis_err", err, 1'b1);
      chk1("mis_valid", instr_valid, 1'b0);
      chk1("mis_rd", imem_rd, 1'b0);
    end
    chk16("mis_addr", imem_addr, 16'h0101);

    // halt with an outstanding request: drain then stay halted
    do_reset(1'b0, 0, 3, 1'b0);
    step(0, 16'h0000, 0, 0); chk1("hw_rd_c0", imem_rd, 1'b1);
    step(0, 16'h0000, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 16'h0000, 0, 0);
      chk1("hw_rd", imem_rd, 1'b0);
      chk1("hw_valid", instr_valid, 1'b0);
    end
    step(1, 16'h0200, 0, 0);
    step(0, 16'h0000, 0, 0);
    chk1("hw_halted_redirect_rd", imem_rd, 1'b0);

    // randomized run against the instruction-stream model
    do_reset(1'b0, 1, 2, 1'b1);
    exp_pc = DEF_RESET_PC;
    consumed = 0;
    prev_valid = 1'b0; prev_stall = 1'b0; prev_redirect = 1'b0;
    prev_pc = 16'h0000; prev_instr = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 19) == 0);
      rp = 16'($urandom) & 16'hFFFE;
      s  = ($urandom_range(0, 3) == 0);
      step(r, rp, 1'b0, s);
      chk1("rnd_no_overlap", imem_rd && busy, 1'b0);
      if (prev_valid && prev_stall && !prev_redirect) begin
        chk1("rnd_hold_valid", instr_valid, 1'b1);
        chk16("rnd_hold_pc", pc_out, prev_pc);
        chk16("rnd_hold_instr", instr, prev_instr);
      end
      if (instr_valid && !s) begin
        chk16("rnd_pc_out", pc_out, exp_pc);
        chk16("rnd_pc_plus2", pc_plus2, 16'(pc_out + 16'd2));
        chk16("rnd_instr", instr, mem_word(pc_out));
        exp_pc = 16'(exp_pc + 16'd2);
        consumed++;
      end
      if (r) exp_pc = rp;
      prev_valid = instr_valid; prev_stall = s; prev_redirect = r;
      prev_pc = pc_out; prev_instr = instr;
    end
    chk1("rnd_err", err, 1'b0);
    total++;
    if (consumed < 100) begin
      bad++;
      $display("FAIL rnd_progress: got %0d consumed expected at least 100", consumed);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
